// File: rtl/uart_pkg.sv
// Shared constants for the uart buffering stage: register map, status bit
// positions and the TX/RX sequencer state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXCNT  = 2'd2;
    localparam logic [1:0] REG_TXCNT  = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_OVERFLOW    = 3;
    localparam int ST_TX_ACTIVE   = 4;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_STROBE = 2'd1,
        TX_WAITHI = 2'd2,
        TX_WAITLO = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_ACK     = 2'd1,
        RX_WAITCLR = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop on a full FIFO frees the
// slot for a push in the same cycle, a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge sclk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/uart_buffer.sv
// CPU-facing TX/RX buffering in front of the uart byte handshake.
//   state      | meaning
//   TX_IDLE    | wait for a queued byte and busy_s low, then load u_data
//   TX_STROBE  | u_data settled; u_ss follows in the next cycle
//   TX_WAITHI  | wait for busy_s high, give up after BUSY_TIMEOUT cycles
//   TX_WAITLO  | wait for busy_s low
//   RX_IDLE    | wait for valid_s, capture/queue the byte
//   RX_ACK     | u_rr high for one cycle
//   RX_WAITCLR | wait for valid_s low before re-arming
module uart_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       u_ss,
    output logic [7:0] u_data,
    input  logic       u_busy,
    input  logic [7:0] u_rec_data,
    input  logic       u_rec_valid,
    output logic       u_rr
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic busy_meta, busy_s, valid_meta, valid_s;

    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]          tx_dout;
    logic [DEPTH_LOG2:0] tx_count;
    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]          rx_dout;
    logic [DEPTH_LOG2:0] rx_count;

    tx_state_t   tx_state, tx_next;
    rx_state_t   rx_state, rx_next;
    logic [TW-1:0] tx_timer;
    logic        rx_capture, overflow, overflow_set, overflow_clr;
    logic [7:0]  status;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            busy_meta  <= 1'b0;
            busy_s     <= 1'b0;
            valid_meta <= 1'b0;
            valid_s    <= 1'b0;
        end else begin
            busy_meta  <= u_busy;
            busy_s     <= busy_meta;
            valid_meta <= u_rec_valid;
            valid_s    <= valid_meta;
        end
    end

    assign tx_push = wr && (addr == REG_DATA);
    assign rx_pop  = rd && (addr == REG_DATA);
    assign rx_push = rx_capture;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .sclk(sclk), .reset(reset), .push(tx_push), .din(wdata), .pop(tx_pop),
        .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .sclk(sclk), .reset(reset), .push(rx_push), .din(u_rec_data), .pop(rx_pop),
        .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !busy_s) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_STROBE;
                end
            end
            TX_STROBE: tx_next = TX_WAITHI;
            TX_WAITHI: begin
                if (busy_s)                tx_next = TX_WAITLO;
                else if (tx_timer == '0)   tx_next = TX_IDLE;
            end
            TX_WAITLO: if (!busy_s) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // u_ss is registered off STROBE so u_data is settled a full cycle before it.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            u_data   <= 8'h00;
            u_ss     <= 1'b0;
        end else begin
            tx_state <= tx_next;
            u_ss     <= (tx_state == TX_STROBE);
            if (tx_pop) u_data <= tx_dout;
            if (tx_state == TX_STROBE)
                tx_timer <= TW'(BUSY_TIMEOUT - 1);
            else if (tx_state == TX_WAITHI && tx_timer != '0)
                tx_timer <= tx_timer - TW'(1);
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_capture = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (valid_s) begin
                    rx_capture = 1'b1;
                    rx_next    = RX_ACK;
                end
            end
            RX_ACK:     rx_next = RX_WAITCLR;
            RX_WAITCLR: if (!valid_s) rx_next = RX_IDLE;
            default:    rx_next = RX_IDLE;
        endcase
    end

    // A full RX FIFO still accepts the byte when the CPU pops in the same cycle.
    assign overflow_set = rx_capture && rx_full && !rx_pop;
    assign overflow_clr = wr && (addr == REG_STATUS) && wdata[ST_OVERFLOW];

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            u_rr     <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rx_state <= rx_next;
            u_rr     <= rx_capture;
            overflow <= overflow_set || (overflow && !overflow_clr);
            irq      <= !rx_empty || overflow;
        end
    end

    always_comb begin
        status                 = 8'h00;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_OVERFLOW]    = overflow;
        status[ST_TX_ACTIVE]   = (tx_state != TX_IDLE);
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rdata <= 8'h00;
        end else if (rd) begin
            case (addr)
                REG_DATA:   rdata <= rx_empty ? 8'h00 : rx_dout;
                REG_STATUS: rdata <= status;
                REG_RXCNT:  rdata <= 8'(rx_count);
                default:    rdata <= 8'(tx_count);
            endcase
        end
    end

endmodule
